// File: rtl/bus_mem_pkg.sv
// Shared constants and fault encoding for the bus_mem memory/IO slave.
package bus_mem_pkg;

    localparam logic [31:0] IO_BASE_DEFAULT = 32'hFFFF_0000;

    // Byte offsets inside the 32-byte IO window
    localparam logic [4:0] IO_OFF_GPIO  = 5'h00;
    localparam logic [4:0] IO_OFF_CYCLE = 5'h04;
    localparam logic [4:0] IO_OFF_HALT  = 5'h08;
    localparam logic [4:0] IO_OFF_FAULT = 5'h0C;

    typedef enum logic [1:0] {
        FAULT_NONE     = 2'b00,
        FAULT_ALIGN    = 2'b01,
        FAULT_UNMAPPED = 2'b10,
        FAULT_COLLIDE  = 2'b11
    } fault_t;

endpackage

// File: rtl/bus_mem_decode.sv
// Combinational address decode: region select, IO offset and access fault classification.
module bus_mem_decode
    import bus_mem_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 1024,
    parameter logic [31:0] IO_BASE   = IO_BASE_DEFAULT
) (
    input  logic [31:0] address_i,
    input  logic        read_i,
    input  logic        write_i,
    output logic        sel_ram_o,
    output logic        sel_io_o,
    output logic [4:0]  io_off_o,
    output fault_t      fault_o
);

    // 33 bits so a RAM spanning the full 4 GiB space still compares correctly
    localparam logic [32:0] RamBytes = 33'(MEM_WORDS) << 2;

    logic in_ram;
    logic in_io;

    always_comb begin
        in_ram    = ({1'b0, address_i} < RamBytes);
        in_io     = (address_i[31:5] == IO_BASE[31:5]);
        sel_ram_o = in_ram;
        sel_io_o  = in_io && !in_ram;
        io_off_o  = address_i[4:0];

        fault_o = FAULT_NONE;
        if (read_i && write_i) begin
            fault_o = FAULT_COLLIDE;
        end else if (read_i || write_i) begin
            if (address_i[1:0] != 2'b00) begin
                fault_o = FAULT_ALIGN;
            end else if (!in_ram && !in_io) begin
                fault_o = FAULT_UNMAPPED;
            end
        end
    end

endmodule

// File: rtl/bus_mem.sv
// Word RAM plus a small IO register window on a shared tri-state bus.
module bus_mem
    import bus_mem_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 1024,
`ifdef BUS_MEM_PRELOAD_EN
    parameter string       INIT_FILE = "program.hex",
`endif
    parameter logic [31:0] IO_BASE   = IO_BASE_DEFAULT
) (
    input  logic        clock,
    input  logic        resetn,
    inout  tri   [31:0] bus,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] address,
    output logic [31:0] gpio_out,
    output logic        halt,
    output logic        fault
);

    localparam int unsigned AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    logic [31:0] mem [MEM_WORDS];

    logic        sel_ram;
    logic        sel_io;
    logic [4:0]  io_off;
    fault_t      acc_fault;

    bus_mem_decode #(
        .MEM_WORDS (MEM_WORDS),
        .IO_BASE   (IO_BASE)
    ) u_decode (
        .address_i (address),
        .read_i    (read),
        .write_i   (write),
        .sel_ram_o (sel_ram),
        .sel_io_o  (sel_io),
        .io_off_o  (io_off),
        .fault_o   (acc_fault)
    );

    logic [31:0] gpio_q,  gpio_d;
    logic [31:0] cycle_q, cycle_d;
    logic        halt_q,  halt_d;
    fault_t      code_q,  code_d;

    logic [AW-1:0] word_idx;
    logic          acc_ok;
    logic          wr_ok;
    logic          ram_we;
    logic          io_we;
    logic          fault_clr;
    logic          drive_bus;
    logic [31:0]   rd_data;

    assign word_idx  = address[AW+1:2];
    assign acc_ok    = (acc_fault == FAULT_NONE);
    assign wr_ok     = write && !read && acc_ok;
    assign ram_we    = wr_ok && sel_ram;
    assign io_we     = wr_ok && sel_io;
    assign fault_clr = io_we && (io_off == IO_OFF_FAULT);
    assign drive_bus = read && !write;

    always_comb begin
        rd_data = '0;
        if (acc_ok) begin
            if (sel_ram) begin
                rd_data = mem[word_idx];
            end else if (sel_io) begin
                case (io_off)
                    IO_OFF_GPIO:  rd_data = gpio_q;
                    IO_OFF_CYCLE: rd_data = cycle_q;
                    IO_OFF_HALT:  rd_data = {31'b0, halt_q};
                    IO_OFF_FAULT: rd_data = {30'b0, code_q};
                    default:      rd_data = '0;
                endcase
            end
        end
    end

    assign bus = drive_bus ? rd_data : 'z;

    always_comb begin
        gpio_d  = gpio_q;
        halt_d  = halt_q;
        cycle_d = halt_q ? cycle_q : cycle_q + 32'd1;
        code_d  = code_q;

        if (io_we && (io_off == IO_OFF_GPIO)) gpio_d = bus;
        if (io_we && (io_off == IO_OFF_HALT)) halt_d = 1'b1;

        if (fault_clr) code_d = FAULT_NONE;
        // First fault wins; a clear in the same cycle makes room for the new one
        if (!acc_ok && (code_q == FAULT_NONE || fault_clr)) code_d = acc_fault;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            gpio_q  <= '0;
            cycle_q <= '0;
            halt_q  <= 1'b0;
            code_q  <= FAULT_NONE;
        end else begin
            gpio_q  <= gpio_d;
            cycle_q <= cycle_d;
            halt_q  <= halt_d;
            code_q  <= code_d;
        end
    end

    // RAM is never cleared; sampling resetn here drops a write caught by reset
    always_ff @(posedge clock) begin
        if (resetn && ram_we) mem[word_idx] <= bus;
    end

    assign gpio_out = gpio_q;
    assign halt     = halt_q;
    assign fault    = (code_q != FAULT_NONE);

endmodule

// File: tb/tb_bus_mem.sv
// Self-checking bench for bus_mem: directed scenarios plus randomized traffic vs. a reference model.
module tb_bus_mem;

    localparam logic [31:0] IO       = 32'hFFFF_0000;
    localparam logic [31:0] BUS_IDLE = 32'hFFFF_FFFF;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] tb_drv = '0;
    logic        tb_oe = 1'b0;
    logic [31:0] gpio_out;
    logic        halt;
    logic        fault;
    tri1  [31:0] bus;

    int n_checks = 0;
    int n_pass = 0;
    int edges_since_rst = 0;

    assign bus = tb_oe ? tb_drv : 'z;

    always #5 clock = ~clock;

    always @(posedge clock or negedge resetn) begin
        if (!resetn) edges_since_rst = 0;
        else edges_since_rst++;
    end

    bus_mem #(
        .MEM_WORDS (1024),
        .IO_BASE   (IO)
    ) dut (
        .clock    (clock),
        .resetn   (resetn),
        .bus      (bus),
        .read     (read),
        .write    (write),
        .address  (address),
        .gpio_out (gpio_out),
        .halt     (halt),
        .fault    (fault)
    );

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clock);
        address = a; read = 1'b0; write = 1'b1; tb_drv = d; tb_oe = 1'b1;
        @(posedge clock);
        #1;
        write = 1'b0; tb_oe = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clock);
        address = a; read = 1'b1; write = 1'b0; tb_oe = 1'b0;
        #2;
        d = bus;
        @(posedge clock);
        #1;
        read = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clock);
        resetn = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        n_checks++; if (gpio_out !== 32'h0) $display("FAIL reset_gpio got %h want 0", gpio_out); else n_pass++;
        n_checks++; if (halt !== 1'b0) $display("FAIL reset_halt got %b want 0", halt); else n_pass++;
        n_checks++; if (fault !== 1'b0) $display("FAIL reset_fault got %b want 0", fault); else n_pass++;
        n_checks++; if (bus !== BUS_IDLE) $display("FAIL reset_bus_idle got %h want %h", bus, BUS_IDLE); else n_pass++;
        @(negedge clock);
        address = IO + 32'h4; read = 1'b1;
        #2;
        n_checks++; if (bus !== 32'h0) $display("FAIL reset_cycle got %h want 0", bus); else n_pass++;
        read = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
    endtask

    task automatic test_cycle_halt();
        logic [31:0] d;
        int frozen;
        repeat (10) @(posedge clock);
        bus_read(IO + 32'h4, d);
        n_checks++; if (d !== 32'd10) $display("FAIL cycle_after_10 got %0d want 10", d); else n_pass++;
        bus_write(IO + 32'h8, 32'h0);
        frozen = edges_since_rst;
        n_checks++; if (halt !== 1'b1) $display("FAIL halt_set got %b want 1", halt); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            bus_read(IO + 32'h4, d);
            n_checks++;
            if (d !== 32'(frozen)) $display("FAIL cycle_frozen[%0d] got %0d want %0d", i, d, frozen);
            else n_pass++;
        end
        bus_read(IO + 32'h8, d);
        n_checks++; if (d !== 32'h1) $display("FAIL halt_reg got %h want 1", d); else n_pass++;
        bus_write(IO, 32'h0000_1234);
        n_checks++; if (gpio_out !== 32'h1234) $display("FAIL gpio_after_halt got %h want 1234", gpio_out); else n_pass++;
    endtask

    task automatic test_write_read();
        logic [31:0] d;
        bus_write(32'h10, 32'hDEAD_BEEF);
        bus_read(32'h10, d);
        n_checks++; if (d !== 32'hDEAD_BEEF) $display("FAIL ram_readback got %h want deadbeef", d); else n_pass++;
        #1;
        n_checks++; if (bus !== BUS_IDLE) $display("FAIL bus_release got %h want %h", bus, BUS_IDLE); else n_pass++;
        bus_write(32'hFFC, 32'hC0FF_EE00);
        bus_read(32'hFFC, d);
        n_checks++; if (d !== 32'hC0FF_EE00) $display("FAIL ram_top_word got %h want c0ffee00", d); else n_pass++;
        n_checks++; if (fault !== 1'b0) $display("FAIL ram_top_nofault got %b want 0", fault); else n_pass++;
        bus_read(32'h1000, d);
        n_checks++; if (d !== 32'h0) $display("FAIL ram_end_read got %h want 0", d); else n_pass++;
        bus_read(IO + 32'hC, d);
        n_checks++; if (d !== 32'h2) $display("FAIL ram_end_code got %h want 2", d); else n_pass++;
        bus_write(IO + 32'hC, 32'h0);
    endtask

    task automatic test_misaligned();
        logic [31:0] d;
        bus_write(32'h13, 32'h5555_AAAA);
        n_checks++; if (fault !== 1'b1) $display("FAIL align_fault got %b want 1", fault); else n_pass++;
        bus_read(IO + 32'hC, d);
        n_checks++; if (d !== 32'h1) $display("FAIL align_code got %h want 1", d); else n_pass++;
        bus_read(32'h10, d);
        n_checks++; if (d !== 32'hDEAD_BEEF) $display("FAIL align_ram_kept got %h want deadbeef", d); else n_pass++;
        bus_read(32'h8000_0000, d);
        n_checks++; if (d !== 32'h0) $display("FAIL unmapped_read got %h want 0", d); else n_pass++;
        bus_read(IO + 32'hC, d);
        n_checks++; if (d !== 32'h1) $display("FAIL first_fault_kept got %h want 1", d); else n_pass++;
        bus_write(IO + 32'hC, 32'h0);
        n_checks++; if (fault !== 1'b0) $display("FAIL align_clear got %b want 0", fault); else n_pass++;
    endtask

    task automatic test_collide();
        logic [31:0] d;
        bus_write(32'h0, 32'h0BAD_F00D);
        @(negedge clock);
        address = 32'h0; read = 1'b1; write = 1'b1; tb_oe = 1'b0;
        #2;
        n_checks++; if (bus !== BUS_IDLE) $display("FAIL collide_bus got %h want %h", bus, BUS_IDLE); else n_pass++;
        @(posedge clock);
        #1;
        read = 1'b0; write = 1'b0;
        n_checks++; if (fault !== 1'b1) $display("FAIL collide_fault got %b want 1", fault); else n_pass++;
        bus_read(IO + 32'hC, d);
        n_checks++; if (d !== 32'h3) $display("FAIL collide_code got %h want 3", d); else n_pass++;
        bus_read(32'h0, d);
        n_checks++; if (d !== 32'h0BAD_F00D) $display("FAIL collide_ram_kept got %h want 0badf00d", d); else n_pass++;
        bus_write(IO + 32'hC, 32'hFFFF_FFFF);
        n_checks++; if (fault !== 1'b0) $display("FAIL collide_clear got %b want 0", fault); else n_pass++;
    endtask

    task automatic test_unlisted_io();
        logic [31:0] d;
        logic [31:0] g;
        g = gpio_out;
        bus_write(IO + 32'h10, 32'h1357_9BDF);
        n_checks++; if (fault !== 1'b0) $display("FAIL unlisted_nofault got %b want 0", fault); else n_pass++;
        bus_read(IO + 32'h10, d);
        n_checks++; if (d !== 32'h0) $display("FAIL unlisted_read got %h want 0", d); else n_pass++;
        n_checks++; if (gpio_out !== g) $display("FAIL unlisted_gpio got %h want %h", gpio_out, g); else n_pass++;
    endtask

    task automatic test_random();
        logic [31:0] ram_m [16];
        logic [31:0] gpio_m;
        logic [1:0]  code_m;
        logic [31:0] d;
        logic [31:0] a;
        logic [31:0] data;
        int op;
        int idx;
        gpio_m = gpio_out;
        code_m = 2'b00;
        for (int k = 0; k < 16; k++) begin
            ram_m[k] = $urandom;
            bus_write(32'(k * 4), ram_m[k]);
        end
        for (int n = 0; n < 150; n++) begin
            op   = $urandom_range(0, 5);
            idx  = $urandom_range(0, 15);
            data = $urandom;
            case (op)
                0: begin
                    bus_write(32'(idx * 4), data);
                    ram_m[idx] = data;
                end
                1: begin
                    bus_read(32'(idx * 4), d);
                    n_checks++;
                    if (d !== ram_m[idx]) $display("FAIL rnd_ram[%0d] got %h want %h", idx, d, ram_m[idx]);
                    else n_pass++;
                end
                2: begin
                    bus_write(IO, data);
                    gpio_m = data;
                end
                3, 4: begin
                    a = (op == 3) ? 32'(idx * 4 + $urandom_range(1, 3)) : (32'h4000_0000 | 32'(idx * 4));
                    if ($urandom_range(0, 1) == 1) begin
                        bus_write(a, data);
                    end else begin
                        bus_read(a, d);
                        n_checks++;
                        if (d !== 32'h0) $display("FAIL rnd_fault_read got %h want 0", d); else n_pass++;
                    end
                    if (code_m == 2'b00) code_m = (op == 3) ? 2'b01 : 2'b10;
                end
                default: begin
                    if ($urandom_range(0, 1) == 1) begin
                        bus_read(IO + 32'hC, d);
                        n_checks++;
                        if (d !== {30'b0, code_m}) $display("FAIL rnd_code got %h want %h", d, code_m);
                        else n_pass++;
                    end else begin
                        bus_write(IO + 32'hC, data);
                        code_m = 2'b00;
                    end
                end
            endcase
            n_checks++;
            if (gpio_out !== gpio_m) $display("FAIL rnd_gpio got %h want %h", gpio_out, gpio_m); else n_pass++;
            n_checks++;
            if (fault !== (code_m != 2'b00)) $display("FAIL rnd_fault got %b want %b", fault, code_m != 2'b00);
            else n_pass++;
        end
        bus_write(IO + 32'hC, 32'h0);
    endtask

    task automatic test_reset_mid_write();
        logic [31:0] d;
        bus_write(32'h20, 32'h1111_1111);
        @(negedge clock);
        address = 32'h20; read = 1'b0; write = 1'b1; tb_drv = 32'h2222_2222; tb_oe = 1'b1;
        #2;
        resetn = 1'b0;
        @(posedge clock);
        #1;
        write = 1'b0; tb_oe = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        bus_read(32'h20, d);
        n_checks++; if (d !== 32'h1111_1111) $display("FAIL reset_abort_write got %h want 11111111", d); else n_pass++;
    endtask

    task automatic test_async_reset();
        bus_write(IO, 32'h0000_00A5);
        n_checks++; if (gpio_out !== 32'hA5) $display("FAIL gpio_write got %h want a5", gpio_out); else n_pass++;
        @(negedge clock);
        #2;
        resetn = 1'b0;
        #1;
        n_checks++; if (gpio_out !== 32'h0) $display("FAIL async_reset_gpio got %h want 0", gpio_out); else n_pass++;
        @(negedge clock);
        resetn = 1'b1;
    endtask

    initial begin
        test_reset();
        test_cycle_halt();
        apply_reset();
        n_checks++; if (halt !== 1'b0) $display("FAIL halt_cleared got %b want 0", halt); else n_pass++;
        test_write_read();
        test_misaligned();
        test_collide();
        test_unlisted_io();
        test_random();
        test_reset_mid_write();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/bus_mem.md
BUS_MEM -- requirements
Module: bus_mem

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 1024, meaning RAM depth in 32-bit words (power of two).
REQ-002 SHALL have parameter IO_BASE, default 32'hFFFF_0000, meaning base byte address of the I/O register window.
REQ-003 SHALL have port clock  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port bus  inout tri  32  shared data bus, driven by this block only on reads.
REQ-006 SHALL have port read  input  1  initiator read strobe.
REQ-007 SHALL have port write  input  1  initiator write strobe.
REQ-008 SHALL have port address  input  32  byte address from initiator.
REQ-009 SHALL have port gpio_out  output  32  GPIO register contents.
REQ-010 SHALL have port halt  output  1  sticky halt flag.
REQ-011 SHALL have port fault  output  1  high while a fault code is latched.

Function
REQ-012 Address decode: RAM when address < MEM_WORDS*4; IO when address[31:5] == IO_BASE[31:5]; otherwise unmapped.
REQ-013 Read: read=1, write=0 -> bus driven combinationally in the same cycle; RAM word index address[31:2]; zero added latency.
REQ-014 Bus SHALL be 'z on all 32 bits whenever read=0 or write=1, including during reset.
REQ-015 Write: write=1, read=0, aligned, mapped -> target updated at next rising edge; bus sampled as write data.
REQ-016 IO map (byte offsets): 0x00 GPIO (RW), 0x04 CYCLE (RO), 0x08 HALT (write any value sets halt; reads {31'b0,halt}), 0x0C FAULT (reads {30'b0,code}; any write clears code to 0).
REQ-017 Unlisted IO offsets SHALL read 0 and ignore writes without faulting.
REQ-018 CYCLE: 32-bit counter, +1 per clock while halt=0, frozen while halt=1, wraps 32'hFFFF_FFFF -> 0.
REQ-019 Fault code 2 bits: 00 none, 01 misaligned (address[1:0] != 0 on read or write), 10 unmapped access, 11 read and write both high.
REQ-020 Only the first fault is latched; later faults leave the code unchanged until it is cleared.
REQ-021 A faulting access SHALL NOT modify RAM or IO state; faulting reads drive 32'h0.
REQ-022 Simultaneous FAULT-register clear and a new fault in the same cycle: the new fault's code is latched.
REQ-023 fault = (code != 00), registered.
REQ-024 Writes after halt=1 SHALL still be accepted; only CYCLE freezes.

Reset
REQ-025 On resetn low, gpio_out=0, halt=0, fault code=00, CYCLE=0, asynchronously.
REQ-026 RAM contents SHALL NOT be reset; they are undefined unless preloaded (REQ-028).
REQ-027 Reset asserted mid-write SHALL abort the write; no partial update.

Configuration
REQ-028 Macro BUS_MEM_PRELOAD_EN defined: RAM initialised at elaboration from hex file named by parameter INIT_FILE (default "program.hex"); undefined: no initialisation, INIT_FILE parameter absent.

Structure
REQ-029 Package bus_mem_pkg SHALL hold IO_BASE default, IO offset constants, and enum fault_t (FAULT_NONE, FAULT_ALIGN, FAULT_UNMAPPED, FAULT_COLLIDE).
REQ-030 One sub-module, bus_mem_decode: combinational, address/read/write -> region select, IO offset, fault_t.
REQ-031 RAM SHALL be a single unpacked array of MEM_WORDS x 32 bits inside bus_mem.

Verification
REQ-032 Write 32'hDEAD_BEEF to 0x0000_0010, then read 0x0000_0010 -> bus = 32'hDEAD_BEEF in the read cycle; bus = 'z in the cycle after read drops.
REQ-033 Hold reset release for 10 clocks, read IO_BASE+0x04 -> 10 (+/-0 relative to the bench's own count); write IO_BASE+0x08 -> halt=1, CYCLE constant over next 5 reads.
REQ-034 Write to 0x0000_0013 -> fault=1 next cycle, FAULT reads 01, RAM word 4 unchanged; then read 0x8000_0000 -> code stays 01.
REQ-035 read=1 and write=1 at 0x0 with code=00 -> bus 'z, code 11, RAM word 0 unchanged; write IO_BASE+0x0C -> fault=0.
REQ-036 Write GPIO 32'h0000_00A5 then assert resetn low mid-cycle -> gpio_out=0 immediately, without waiting for a clock edge.
